// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
// The optional statistics counters are enabled with the ARB_STATS_EN macro.
package arb_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    // Preemption bound used when the top is instantiated without overrides
    localparam int unsigned MAX_HOLD_DEFAULT = 4;

    // Width of the optional per-requester grant-entry counters
    localparam int unsigned CNT_W = 16;

    // One-hot grant vector implied by a state; the unused encoding grants nobody
    function automatic logic [1:0] gnt_of(arb_state_e s);
        logic [1:0] g;
        g = 2'b00;
        if (s == G0) g = 2'b01;
        if (s == G1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// Hold counter: counts consecutive contended cycles in the current grant
// and flags when the holder has used its last allowed contended cycle.
module arb_hold_cnt #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [3:0] cnt;

    // Clear has priority so every state change starts a fresh hold window
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 4'd0;
        end else if (en) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Terminal count: this contended cycle is the holder's last one
    always_comb begin
        tc = (cnt == 4'(MAX_HOLD - 1));
    end

endmodule

// File: rtl/moore_rr_arbiter.sv
// Two-requester Moore round-robin arbiter with bounded hold.
// Grant and mux select decode from the state register only; the data mux
// itself is combinational on the source data.
// Optional macro ARB_STATS_EN adds stats_clr, cnt0 and cnt1.
module moore_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned DW       = 3,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [DW-1:0]    data0,
    input  logic [DW-1:0]    data1,
`ifdef ARB_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
`endif
    output logic [1:0]       gnt,
    output logic [DW-1:0]    y,
    output logic             valid
);

    arb_state_e state, state_d;
    logic       last, last_d;   // requester served most recently
    logic       hold_en;
    logic       hold_clr;
    logic       hold_tc;

    arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hold_clr),
        .en  (hold_en),
        .tc  (hold_tc)
    );

    // State and last-served pointer registers; last=1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_d;
            last  <= last_d;
        end
    end

    // Next-state, pointer update and hold-counter control
    always_comb begin
        state_d = state;
        last_d  = last;
        hold_en = 1'b0;

        unique case (state)
            IDLE: begin
                unique case (req)
                    2'b01:   state_d = G0;
                    2'b10:   state_d = G1;
                    2'b11:   state_d = last ? G0 : G1;
                    default: state_d = IDLE;
                endcase
            end
            G0: begin
                if (!req[0]) begin
                    state_d = req[1] ? G1 : IDLE;
                end else if (req[1]) begin
                    if (hold_tc) state_d = G1;
                    else         hold_en = 1'b1;
                end
            end
            G1: begin
                if (!req[1]) begin
                    state_d = req[0] ? G0 : IDLE;
                end else if (req[0]) begin
                    if (hold_tc) state_d = G0;
                    else         hold_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == G0 && state != G0) last_d = 1'b0;
        if (state_d == G1 && state != G1) last_d = 1'b1;

        // Any state change restarts the hold window
        hold_clr = (state_d != state);
    end

    // Moore output decode plus data forwarding from the granted source
    always_comb begin
        gnt   = gnt_of(state);
        valid = |gnt;
        y     = '0;
        if (gnt[0]) y = data0;
        if (gnt[1]) y = data1;
    end

`ifdef ARB_STATS_EN
    logic enter0, enter1;

    always_comb begin
        enter0 = (state_d == G0) && (state != G0);
        enter1 = (state_d == G1) && (state != G1);
    end

    // Saturating grant-entry counters; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (enter0 && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
            if (enter1 && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Self-checking bench for moore_rr_arbiter: directed vector table plus
// hand-written preemption and (with ARB_STATS_EN) counter sequences.
module tb_moore_rr_arbiter;

    localparam logic [2:0] D0 = 3'b101;
    localparam logic [2:0] D1 = 3'b010;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [2:0] d0;
        logic [2:0] d1;
        logic [1:0] gnt;
        logic [2:0] y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [2:0]  data0, data1;
    logic [1:0]  gnt;
    logic [2:0]  y;
    logic        valid;
`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] cnt0, cnt1;
`endif

    int applied = 0;
    int errors  = 0;
    vec_t vecs[$];

    moore_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
`ifdef ARB_STATS_EN
        .stats_clr (stats_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
`endif
        .gnt       (gnt),
        .y         (y),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] rq, input logic [2:0] a,
                       input logic [2:0] b, input logic [1:0] g, input logic [2:0] yy);
        vec_t v;
        v.rst = r; v.req = rq; v.d0 = a; v.d1 = b; v.gnt = g; v.y = yy;
        vecs.push_back(v);
    endtask

    // Apply inputs, clock once, then compare outputs 1ns after the edge
    task automatic step(input string name, input logic r, input logic [1:0] rq,
                        input logic [2:0] a, input logic [2:0] b,
                        input logic [1:0] eg, input logic [2:0] ey);
        rst = r; req = rq; data0 = a; data1 = b;
        @(posedge clk);
        #1;
        applied++;
        if (gnt !== eg || y !== ey || valid !== (|eg)) begin
            errors++;
            $display("FAIL %s: gnt=%b y=%b valid=%b, expected gnt=%b y=%b valid=%b",
                     name, gnt, y, valid, eg, ey, |eg);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 2'b00; data0 = D0; data1 = D1;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #1;

        // Reset held with both requesting
        add(1, 2'b11, D0, D1, 2'b00, 3'b000);
        add(1, 2'b11, D0, D1, 2'b00, 3'b000);
        // Release: requester 0 wins first, then 4 cycles each under contention
        add(0, 2'b11, D0, D1, 2'b01, D0);
        add(0, 2'b11, 3'b011, D1, 2'b01, 3'b011);
        add(0, 2'b11, D0, D1, 2'b01, D0);
        add(0, 2'b11, D0, D1, 2'b01, D0);
        add(0, 2'b11, D0, 3'b110, 2'b10, 3'b110);
        add(0, 2'b11, D0, D1, 2'b10, D1);
        add(0, 2'b11, D0, D1, 2'b10, D1);
        add(0, 2'b11, D0, D1, 2'b10, D1);
        add(0, 2'b11, D0, D1, 2'b01, D0);
        // Single requester never preempted
        for (int i = 0; i < 10; i++) add(0, 2'b01, D0, D1, 2'b01, D0);
        add(0, 2'b00, D0, D1, 2'b00, 3'b000);
        // Fairness from IDLE: last served was 0, so 1 wins, then 0
        add(0, 2'b11, D0, D1, 2'b10, D1);
        add(0, 2'b00, D0, D1, 2'b00, 3'b000);
        add(0, 2'b11, D0, D1, 2'b01, D0);
        add(0, 2'b00, D0, D1, 2'b00, 3'b000);
        // Handover in one edge, then reset mid-grant
        add(0, 2'b10, D0, D1, 2'b10, D1);
        add(0, 2'b10, D0, D1, 2'b10, D1);
        add(0, 2'b01, D0, D1, 2'b01, D0);
        add(1, 2'b01, D0, D1, 2'b00, 3'b000);
        add(0, 2'b01, D0, D1, 2'b01, D0);
        add(0, 2'b00, D0, D1, 2'b00, 3'b000);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].d0,
                 vecs[i].d1, vecs[i].gnt, vecs[i].y);
        end

        // Sustained contention: 01 x4, 10 x4, ... with no gap and never 11
        step("preempt_rst", 1, 2'b11, D0, D1, 2'b00, 3'b000);
        for (int i = 0; i < 16; i++) begin
            if (((i / 4) % 2) == 0)
                step($sformatf("preempt%0d", i), 0, 2'b11, D0, D1, 2'b01, D0);
            else
                step($sformatf("preempt%0d", i), 0, 2'b11, D0, D1, 2'b10, D1);
        end

`ifdef ARB_STATS_EN
        // 3 entries into G0 and 2 into G1
        step("st_rst", 1, 2'b00, D0, D1, 2'b00, 3'b000);
        step("st_a", 0, 2'b01, D0, D1, 2'b01, D0);
        step("st_b", 0, 2'b00, D0, D1, 2'b00, 3'b000);
        step("st_c", 0, 2'b01, D0, D1, 2'b01, D0);
        step("st_d", 0, 2'b10, D0, D1, 2'b10, D1);
        step("st_e", 0, 2'b01, D0, D1, 2'b01, D0);
        step("st_f", 0, 2'b10, D0, D1, 2'b10, D1);
        step("st_g", 0, 2'b00, D0, D1, 2'b00, 3'b000);
        applied++;
        if (cnt0 !== 16'd3 || cnt1 !== 16'd2) begin
            errors++;
            $display("FAIL stats_count: cnt0=%0d cnt1=%0d, expected 3 and 2", cnt0, cnt1);
        end
        stats_clr = 1'b1;
        step("st_clr", 0, 2'b00, D0, D1, 2'b00, 3'b000);
        stats_clr = 1'b0;
        applied++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: cnt0=%0d cnt1=%0d, expected 0 and 0", cnt0, cnt1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
